// File: rtl/tiny_fpga_flash_loader_if.sv
// One-beat AXI-stream link between the flash loader and the fabric
// configuration slave.
interface axi_stream_if #(
   parameter int DATA_WIDTH = 1
) ();
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/tiny_fpga_flash_loader.sv
// Reads a fixed-length bitstream from SPI NOR flash (READ 0x03) and streams it
// bit by bit into the fabric configuration slave; SCK is paced by tready.
module tiny_fpga_flash_loader #(
   parameter int          BITSTREAM_BITS  = 1024,
   parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000,
   parameter int          SCK_HALF_PERIOD = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         spi_cs_n,
   output logic         spi_sck,
   output logic         spi_mosi,
   input  logic         spi_miso,
   axi_stream_if.master bitstream,
   output logic         cfg,
   input  logic         cfg_ready,
   output logic         busy,
   output logic         done
);

   localparam int          CNT_W    = $clog2(BITSTREAM_BITS + 1);
   localparam int          DIV_W    = $clog2(SCK_HALF_PERIOD + 1);
   localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE_ADDR};

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CMD      = 3'd1,
      READ     = 3'd2,
      DRAIN    = 3'd3,
      WAIT_CFG = 3'd4
   } state_t;

   state_t             state_r;
   logic [30:0]        shreg_r;
   logic [4:0]         cmd_cnt_r;
   logic [DIV_W-1:0]   div_r;
   logic [CNT_W-1:0]   beat_cnt_r;
   logic               all_read_r;
   logic               cs_n_r;
   logic               sck_r;
   logic               mosi_r;
   logic               tvalid_r;
   logic               tdata_r;
   logic               tlast_r;
   logic               cfg_r;
   logic               busy_r;
   logic               done_r;

   logic               hs_s;
   logic               phase_end_s;
   logic               last_idx_s;

   assign hs_s        = tvalid_r & bitstream.tready;
   assign phase_end_s = (div_r == DIV_W'(SCK_HALF_PERIOD - 1));
   // Index of the bit about to be sampled: beats already accepted plus the one accepted now.
   assign last_idx_s  = ((beat_cnt_r + CNT_W'(hs_s)) == CNT_W'(BITSTREAM_BITS - 1));

   // Loader state machine, SCK generation, flash shifting and stream holding register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         shreg_r    <= 31'd0;
         cmd_cnt_r  <= 5'd0;
         div_r      <= '0;
         beat_cnt_r <= '0;
         all_read_r <= 1'b0;
         cs_n_r     <= 1'b1;
         sck_r      <= 1'b0;
         mosi_r     <= 1'b0;
         tvalid_r   <= 1'b0;
         tdata_r    <= 1'b0;
         tlast_r    <= 1'b0;
         cfg_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (hs_s) begin
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
         end
         case (state_r)
            IDLE: begin
               cs_n_r <= 1'b1;
               sck_r  <= 1'b0;
               mosi_r <= 1'b0;
               if (start) begin
                  cs_n_r     <= 1'b0;
                  cfg_r      <= 1'b1;
                  busy_r     <= 1'b1;
                  mosi_r     <= CMD_WORD[31];
                  shreg_r    <= CMD_WORD[30:0];
                  cmd_cnt_r  <= 5'd0;
                  div_r      <= '0;
                  beat_cnt_r <= '0;
                  all_read_r <= 1'b0;
                  state_r    <= CMD;
               end else begin
                  cfg_r  <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            CMD: begin
               if (!phase_end_s) begin
                  div_r <= div_r + DIV_W'(1);
               end else begin
                  div_r <= '0;
                  sck_r <= ~sck_r;
                  // MOSI changes together with the falling edge, so it is settled for the next rise.
                  if (sck_r) begin
                     if (cmd_cnt_r == 5'd31) begin
                        mosi_r  <= 1'b0;
                        state_r <= READ;
                     end else begin
                        mosi_r    <= shreg_r[30];
                        shreg_r   <= {shreg_r[29:0], 1'b0};
                        cmd_cnt_r <= cmd_cnt_r + 5'd1;
                     end
                  end
               end
            end
            READ: begin
               if (!sck_r) begin
                  if (!phase_end_s) begin
                     div_r <= div_r + DIV_W'(1);
                  end else if (!tvalid_r || bitstream.tready) begin
                     div_r    <= '0;
                     sck_r    <= 1'b1;
                     tvalid_r <= 1'b1;
                     tdata_r  <= spi_miso;
                     tlast_r  <= last_idx_s;
                     if (last_idx_s) begin
                        all_read_r <= 1'b1;
                     end
                  end
               end else if (phase_end_s) begin
                  div_r <= '0;
                  sck_r <= 1'b0;
                  if (all_read_r) begin
                     state_r <= DRAIN;
                  end
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            DRAIN: begin
               if (!tvalid_r || hs_s) begin
                  cs_n_r  <= 1'b1;
                  state_r <= WAIT_CFG;
               end
            end
            WAIT_CFG: begin
               if (cfg_ready) begin
                  cfg_r   <= 1'b0;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign spi_cs_n         = cs_n_r;
   assign spi_sck          = sck_r;
   assign spi_mosi         = mosi_r;
   assign bitstream.tvalid = tvalid_r;
   assign bitstream.tdata  = tdata_r;
   assign bitstream.tlast  = tlast_r;
   assign cfg              = cfg_r;
   assign busy             = busy_r;
   assign done             = done_r;

endmodule
